// File: rtl/prio_enc_seg_sync.sv
// prio_enc_seg_sync
//   Clocked priority encoder with seven-segment readout. Raw switch inputs are
//   brought into the clock domain by a two-flop synchroniser. A debouncer then
//   filters them, and the highest set bit of the debounced vector is encoded.
//   The code, a valid flag and a change pulse are registered. A saturating count
//   of change pulses is kept, and the registered code is shown as an active-low
//   hex digit.
//
// Parameters
//   N       input vector width (2..16)
//   STABLE  debounce length in cycles (1..255)
//   CNT_W   event counter width
//   W       code width, derived from N
//
// Ports
//   clk_i      system clock, rising edge
//   rst_ni     asynchronous active-low reset
//   x_i        raw switch inputs, asynchronous to clk_i
//   en_i       encoder enable; 0 forces code 0 / invalid
//   hold_i     1 = keep the last valid code while the input is all-zero
//   clr_i      synchronous clear of evt_cnt_o (wins over increment)
//   y_o        index of the highest set bit
//   sig_o      valid flag
//   chg_o      one-cycle pulse when y_o or sig_o changed
//   evt_cnt_o  saturating count of chg_o pulses
//   seg_o      active-low hex digit of y_o, seg_o[0]=a .. seg_o[6]=g, 7'h7F = blank

module prio_enc_seg_sync #(
  parameter int unsigned N      = 8,
  parameter int unsigned STABLE = 4,
  parameter int unsigned CNT_W  = 8,
  localparam int unsigned W     = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     x_i,
  input  logic             en_i,
  input  logic             hold_i,
  input  logic             clr_i,
  output logic [W-1:0]     y_o,
  output logic             sig_o,
  output logic             chg_o,
  output logic [CNT_W-1:0] evt_cnt_o,
  output logic [6:0]       seg_o
);

  // STABLE is at most 255, so an 8-bit run counter always suffices.
  localparam int unsigned DbW = 8;
  localparam logic [DbW-1:0] DbLast = DbW'(STABLE - 1);
  localparam logic [CNT_W-1:0] EvtMax = {CNT_W{1'b1}};

  // Synchroniser stages.
  logic [N-1:0] s1_q, s2_q;

  // Debouncer state.
  logic [N-1:0]   cand_q, cand_d;
  logic [DbW-1:0] cnt_q, cnt_d;
  logic [N-1:0]   stab_q, stab_d;

  // Output register and event counter.
  logic [W-1:0]     y_q, y_d;
  logic             sig_q, sig_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] evt_q, evt_d;

  // Priority encoder outputs.
  logic [W-1:0] enc_y;
  logic         enc_v;

  // ---------------------------------------------------------------------------
  // Debounce: a new value must sit unchanged at s2 for STABLE+1 cycles before
  // it is copied into stab. The counter then holds at its last value, so stab
  // is simply reloaded with the same candidate until s2 moves again.
  // ---------------------------------------------------------------------------
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    stab_d = stab_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q == DbLast) begin
      stab_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Priority encoder: the scan runs in ascending order, so the last hit is the
  // highest set index.
  // ---------------------------------------------------------------------------
  always_comb begin
    enc_y = '0;
    enc_v = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (stab_q[i]) begin
        enc_y = W'(i);
        enc_v = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next output state. en has the highest priority. hold keeps the current
  // registered code only while the debounced input is empty. en and hold are
  // sampled every cycle, so dropping either takes effect on the next edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    y_d   = enc_y;
    sig_d = enc_v;
    if (!en_i) begin
      y_d   = '0;
      sig_d = 1'b0;
    end else if (!enc_v && hold_i) begin
      y_d   = y_q;
      sig_d = sig_q;
    end
    chg_d = (y_d != y_q) || (sig_d != sig_q);
  end

  // The counter counts registered chg pulses. clr wins over an increment
  // in the same cycle.
  always_comb begin
    evt_d = evt_q;
    if (clr_i) begin
      evt_d = '0;
    end else if (chg_q && (evt_q != EvtMax)) begin
      evt_d = evt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
      stab_q <= '0;
      y_q    <= '0;
      sig_q  <= 1'b0;
      chg_q  <= 1'b0;
      evt_q  <= '0;
    end else begin
      s1_q   <= x_i;
      s2_q   <= s1_q;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      stab_q <= stab_d;
      y_q    <= y_d;
      sig_q  <= sig_d;
      chg_q  <= chg_d;
      evt_q  <= evt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Seven-segment decode. It reads only registered state, so activity on x_i
  // cannot glitch the display.
  // ---------------------------------------------------------------------------
  logic [3:0] y_hex;
  logic [6:0] glyph;

  always_comb begin
    y_hex          = '0;
    y_hex[W-1:0]   = y_q;
  end

  always_comb begin
    glyph = 7'h7F;
    case (y_hex)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  end

  assign y_o       = y_q;
  assign sig_o     = sig_q;
  assign chg_o     = chg_q;
  assign evt_cnt_o = evt_q;
  assign seg_o     = sig_q ? glyph : 7'h7F;

endmodule

// File: tb/tb_prio_enc_seg_sync.sv
module tb_prio_enc_seg_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  x;
  logic [15:0] x16;
  logic        en, hold, clr;
  logic [2:0]  y;
  logic        sig, chg;
  logic [7:0]  evt;
  logic [6:0]  seg;
  logic [3:0]  y16;
  logic        sig16, chg16;
  logic [7:0]  evt16;
  logic [6:0]  seg16;

  always #5 clk = ~clk;

  prio_enc_seg_sync #(.N(8), .STABLE(4), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .x_i(x), .en_i(en), .hold_i(hold), .clr_i(clr),
    .y_o(y), .sig_o(sig), .chg_o(chg), .evt_cnt_o(evt), .seg_o(seg)
  );

  prio_enc_seg_sync #(.N(16), .STABLE(4), .CNT_W(8)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .x_i(x16), .en_i(en), .hold_i(hold), .clr_i(clr),
    .y_o(y16), .sig_o(sig16), .chg_o(chg16), .evt_cnt_o(evt16), .seg_o(seg16)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] x;
    logic       en;
    logic       hold;
    logic [2:0] y;
    logic       sig;
    logic [6:0] seg;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles and count the chg pulses seen.
  task automatic run(input int n, output int nchg);
    nchg = 0;
    repeat (n) begin
      tick();
      if (chg === 1'b1) nchg++;
    end
  endtask

  initial begin
    int  n;
    bit  saw6;

    vecs[0]  = '{8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 7'h7F};
    vecs[1]  = '{8'h01, 1'b1, 1'b0, 3'd0, 1'b1, 7'h40};
    vecs[2]  = '{8'h03, 1'b1, 1'b0, 3'd1, 1'b1, 7'h79};
    vecs[3]  = '{8'h04, 1'b1, 1'b0, 3'd2, 1'b1, 7'h24};
    vecs[4]  = '{8'h0F, 1'b1, 1'b0, 3'd3, 1'b1, 7'h30};
    vecs[5]  = '{8'h10, 1'b1, 1'b0, 3'd4, 1'b1, 7'h19};
    vecs[6]  = '{8'h3F, 1'b1, 1'b0, 3'd5, 1'b1, 7'h12};
    vecs[7]  = '{8'h41, 1'b1, 1'b0, 3'd6, 1'b1, 7'h02};
    vecs[8]  = '{8'h00, 1'b1, 1'b1, 3'd6, 1'b1, 7'h02};
    vecs[9]  = '{8'h80, 1'b1, 1'b0, 3'd7, 1'b1, 7'h78};
    vecs[10] = '{8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 7'h7F};
    vecs[11] = '{8'hAA, 1'b1, 1'b0, 3'd7, 1'b1, 7'h78};

    rst_n = 1'b0; x = '0; x16 = '0; en = 1'b1; hold = 1'b0; clr = 1'b0;
    repeat (3) tick();
    check("rst_y", 32'(y), 0);
    check("rst_sig", 32'(sig), 0);
    check("rst_chg", 32'(chg), 0);
    check("rst_evt", 32'(evt), 0);
    check("rst_seg", 32'(seg), 32'h7F);
    rst_n = 1'b1;

    // Reset in the middle of a cycle clears the outputs without a clock edge.
    x = 8'h01;
    run(12, n);
    check("pre_rst_y", 32'(y), 0);
    check("pre_rst_sig", 32'(sig), 1);
    check("pre_rst_seg", 32'(seg), 32'h40);
    x = 8'hFF;
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_y", 32'(y), 0);
    check("async_rst_sig", 32'(sig), 0);
    check("async_rst_seg", 32'(seg), 32'h7F);
    check("async_rst_evt", 32'(evt), 0);
    tick();
    #2 rst_n = 1'b1;
    // The next rising edge is E1. The output must update at E8.
    repeat (7) tick();
    check("lat_e7_sig", 32'(sig), 0);
    tick();
    check("lat_e8_y", 32'(y), 7);
    check("lat_e8_sig", 32'(sig), 1);
    check("lat_e8_chg", 32'(chg), 1);
    tick();
    check("lat_e9_chg", 32'(chg), 0);
    check("lat_evt", 32'(evt), 1);

    // Priority encoding.
    x = 8'b0010_0110;
    run(12, n);
    check("prio_y", 32'(y), 5);
    check("prio_sig", 32'(sig), 1);
    check("prio_seg", 32'(seg), 32'h12);
    check("prio_nchg", 32'(n), 1);
    check("prio_evt", 32'(evt), 2);

    // A 3-cycle glitch is filtered out. A 6-cycle pulse passes through.
    x = 8'h66;
    repeat (3) tick();
    x = 8'h26;
    run(15, n);
    check("glitch_nchg", 32'(n), 0);
    check("glitch_y", 32'(y), 5);
    check("glitch_evt", 32'(evt), 2);
    x = 8'h66;
    repeat (6) tick();
    x = 8'h26;
    n = 0; saw6 = 1'b0;
    repeat (20) begin
      tick();
      if (chg === 1'b1) n++;
      if (y === 3'd6) saw6 = 1'b1;
    end
    check("pulse_saw6", 32'(saw6), 1);
    check("pulse_nchg", 32'(n), 2);
    check("pulse_y", 32'(y), 5);
    check("pulse_evt", 32'(evt), 4);

    // hold keeps the last code while the input is all-zero.
    hold = 1'b1;
    x = 8'h08;
    run(12, n);
    check("hold_y3", 32'(y), 3);
    check("hold_nchg1", 32'(n), 1);
    x = 8'h00;
    run(12, n);
    check("hold_keep_y", 32'(y), 3);
    check("hold_keep_sig", 32'(sig), 1);
    check("hold_keep_nchg", 32'(n), 0);
    hold = 1'b0;
    tick();
    check("unhold_y", 32'(y), 0);
    check("unhold_sig", 32'(sig), 0);
    check("unhold_chg", 32'(chg), 1);
    tick();
    check("unhold_evt", 32'(evt), 6);

    // en=0 blanks the output. en=1 re-displays the code one edge later.
    en = 1'b0;
    x = 8'h80;
    run(12, n);
    check("en0_sig", 32'(sig), 0);
    check("en0_seg", 32'(seg), 32'h7F);
    check("en0_nchg", 32'(n), 0);
    en = 1'b1;
    tick();
    check("en1_y", 32'(y), 7);
    check("en1_sig", 32'(sig), 1);
    check("en1_chg", 32'(chg), 1);

    // Table of steady-state vectors.
    for (int i = 0; i < 12; i++) begin
      x = vecs[i].x; en = vecs[i].en; hold = vecs[i].hold;
      run(12, n);
      check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].y));
      check($sformatf("vec%0d_sig", i), 32'(sig), 32'(vecs[i].sig));
      check($sformatf("vec%0d_seg", i), 32'(seg), 32'(vecs[i].seg));
    end
    en = 1'b1; hold = 1'b0;

    // 16-bit build.
    x16 = 16'h8001;
    run(12, n);
    check("n16_y", 32'(y16), 15);
    check("n16_sig", 32'(sig16), 1);
    check("n16_seg", 32'(seg16), 32'h0E);
    x16 = 16'h0400;
    run(12, n);
    check("n16_y10", 32'(y16), 10);
    check("n16_seg10", 32'(seg16), 32'h08);

    // Counter saturation and clear priority.
    x = 8'h80;
    run(12, n);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_evt", 32'(evt), 0);
    repeat (300) begin
      en = ~en;
      tick();
    end
    check("sat_evt", 32'(evt), 255);
    en = ~en; clr = 1'b1;
    tick();
    check("clr_chg_busy", 32'(chg), 1);
    check("clr_vs_inc", 32'(evt), 0);
    en = ~en; clr = 1'b0;
    tick();
    check("post_clr_evt", 32'(evt), 1);
    en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
